// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types for the APB requester
package apb_pkg;

  // Transfer phase of the requester FSM.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_req_state_t;

  // Response status flags; data width stays a module parameter.
  typedef struct packed {
    logic slverr;
    logic timeout;
  } apb_rsp_status_t;

endpackage

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - single-outstanding APB4 requester with access timeout
module apb_requester
  import apb_pkg::*;
#(
  parameter int G_REGWIDTH   = 32,
  parameter int G_ADDR_WIDTH = 32,
  parameter int G_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [G_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [G_REGWIDTH-1:0]     cmd_wdata,
  input  logic [G_REGWIDTH/8-1:0]   cmd_strb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [G_REGWIDTH-1:0]     rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic                      m_apb_psel,
  output logic                      m_apb_penable,
  output logic                      m_apb_pwrite,
  output logic [G_ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic [G_REGWIDTH-1:0]     m_apb_pwdata,
  output logic [G_REGWIDTH/8-1:0]   m_apb_pstrb,
  input  logic                      m_apb_pready,
  input  logic [G_REGWIDTH-1:0]     m_apb_prdata,
  input  logic                      m_apb_pslverr
);

  localparam int STRB_W  = G_REGWIDTH / 8;
  localparam int CNT_W   = (G_TIMEOUT > 0) ? $clog2(G_TIMEOUT + 1) : 1;
  localparam int TO_LAST = (G_TIMEOUT > 0) ? G_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST_C = TO_LAST[CNT_W-1:0];

  apb_req_state_t          state;
  logic                    ready_q;
  logic [CNT_W-1:0]        to_cnt;
  apb_rsp_status_t         status_q;
  logic [G_REGWIDTH-1:0]   rdata_q;
  logic                    pwrite_q;
  logic [G_ADDR_WIDTH-1:0] paddr_q;
  logic [G_REGWIDTH-1:0]   pwdata_q;
  logic [STRB_W-1:0]       pstrb_q;
  logic                    timeout_hit;

  // The counter holds the number of ACCESS cycles already spent without
  // pready, so the last allowed cycle is the one where it reads G_TIMEOUT-1.
  assign timeout_hit = (G_TIMEOUT != 0) && (to_cnt == TO_LAST_C);

  // FSM, command capture, timeout counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      to_cnt   <= '0;
      status_q <= '0;
      rdata_q  <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && ready_q) begin
            state    <= ST_SETUP;
            ready_q  <= 1'b0;
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            // Reads never drive byte strobes onto the bus.
            pstrb_q  <= cmd_write ? cmd_strb : '0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          state  <= ST_ACCESS;
          to_cnt <= '0;
        end
        ST_ACCESS: begin
          // A real completion beats a timeout landing in the same cycle.
          if (m_apb_pready) begin
            state           <= ST_RESP;
            status_q.slverr  <= m_apb_pslverr;
            status_q.timeout <= 1'b0;
            rdata_q         <= pwrite_q ? '0 : m_apb_prdata;
          end else if (timeout_hit) begin
            state           <= ST_RESP;
            status_q.slverr  <= 1'b1;
            status_q.timeout <= 1'b1;
            rdata_q         <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = ready_q;
  assign rsp_valid     = (state == ST_RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_slverr    = status_q.slverr;
  assign rsp_timeout   = status_q.timeout;
  assign m_apb_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign m_apb_penable = (state == ST_ACCESS);
  assign m_apb_pwrite  = pwrite_q;
  assign m_apb_paddr   = paddr_q;
  assign m_apb_pwdata  = pwdata_q;
  assign m_apb_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - directed and random checks of apb_requester
module tb_apb_requester;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  int checks = 0;
  int errors = 0;

  apb_requester #(
    .G_REGWIDTH  (DW),
    .G_ADDR_WIDTH(AW),
    .G_TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_strb     (cmd_strb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_slverr   (rsp_slverr),
    .rsp_timeout  (rsp_timeout),
    .m_apb_psel   (psel),
    .m_apb_penable(penable),
    .m_apb_pwrite (pwrite),
    .m_apb_paddr  (paddr),
    .m_apb_pwdata (pwdata),
    .m_apb_pstrb  (pstrb),
    .m_apb_pready (pready),
    .m_apb_prdata (prdata),
    .m_apb_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string ph, input logic sel, input logic en, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [SW-1:0] st);
    check({ph, "_psel"}, {63'd0, psel}, {63'd0, sel});
    check({ph, "_penable"}, {63'd0, penable}, {63'd0, en});
    check({ph, "_pwrite"}, {63'd0, pwrite}, {63'd0, wr});
    check({ph, "_paddr"}, {32'd0, paddr}, {32'd0, a});
    check({ph, "_pwdata"}, {32'd0, pwdata}, {32'd0, wd});
    check({ph, "_pstrb"}, {60'd0, pstrb}, {60'd0, st});
  endtask

  // One complete transfer: command, SETUP, ACCESS with 'waits' wait states
  // (completer answers on ACCESS cycle waits+1), then RESP held 'hold' cycles.
  task automatic do_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input int waits, input logic [DW-1:0] rd,
                        input logic err, input int hold);
    logic [SW-1:0] exp_strb;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            n;
    exp_strb = wr ? st : '0;
    if (waits < TO) begin
      exp_rdata = wr ? '0 : rd;
      exp_err   = err;
      exp_to    = 1'b0;
    end else begin
      exp_rdata = '0;
      exp_err   = 1'b1;
      exp_to    = 1'b1;
    end
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_strb  = st;
    @(negedge clk);
    // Scramble the command inputs so the capture registers are exercised.
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
    pready    = 1'($urandom);
    prdata    = $urandom;
    pslverr   = 1'($urandom);
    check_bus("setup", 1'b1, 1'b0, wr, a, wd, exp_strb);
    check("setup_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("setup_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      check_bus("access", 1'b1, 1'b1, wr, a, wd, exp_strb);
      check("access_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      pready  = (k == waits);
      prdata  = (k == waits) ? rd : $urandom;
      pslverr = (k == waits) ? err : 1'($urandom);
      if (k == waits) break;
    end
    @(negedge clk);
    pready    = 1'($urandom);
    prdata    = $urandom;
    pslverr   = 1'($urandom);
    cmd_valid = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rdata});
      check("rsp_slverr", {63'd0, rsp_slverr}, {63'd0, exp_err});
      check("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, exp_to});
      check("resp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      check_bus("resp", 1'b0, 1'b0, wr, a, wd, exp_strb);
      if (h < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("done_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("done_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_bus("done", 1'b0, 1'b0, wr, a, wd, exp_strb);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    pready    = 1'b1;
    prdata    = '0;
    pslverr   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("rst_rsp_slverr", {63'd0, rsp_slverr}, 64'd0);
    check("rst_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    check_bus("rst", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Write, zero wait states.
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 0);
    // Read, 3 wait states; strobes must read as zero.
    do_txn(1'b0, 32'h24, 32'h0, 4'hF, 3, 32'h12345678, 1'b0, 0);
    // Slave error, response held 5 extra cycles with a pending command.
    do_txn(1'b0, 32'h28, 32'h0, 4'hF, 1, 32'hCAFE0001, 1'b1, 5);
    // Timeout, then completion on the last allowed cycle.
    do_txn(1'b0, 32'h2C, 32'h0, 4'hF, 99, 32'h55, 1'b0, 1);
    do_txn(1'b1, 32'h2C, 32'hA5A5A5A5, 4'h3, TO - 1, 32'h0, 1'b0, 0);
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, TO - 1, 32'h0BADF00D, 1'b0, 0);

    // Reset during the second ACCESS cycle.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h34;
    cmd_strb  = 4'hF;
    pready    = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_access1_penable", {63'd0, penable}, 64'd1);
    @(negedge clk);
    check("rst_mid_access2_penable", {63'd0, penable}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_bus("rst_mid", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("after_rst_psel", {63'd0, psel}, 64'd0);
    end
    do_txn(1'b1, 32'h40, 32'h01020304, 4'hF, 0, 32'h0, 1'b0, 0);

    // Random back-to-back traffic including waits that run into the timeout.
    for (int i = 0; i < 100; i++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, 5)), $urandom, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
